// File: rtl/pipe_pkg.sv
// pipe_pkg: shared lane layout, state encoding and bubble constant for the ID->EX stage
package pipe_pkg;
   localparam int NUM_LANES = 2;
   localparam int REG_IDX_W = 5;
   typedef enum logic {ISSUE, SPLIT} state_t;
   // Lane header layout inside a packed lane word; data fields follow at HDR_W
   localparam int V_O   = 0;
   localparam int RS1_O = V_O + 1;
   localparam int RS2_O = RS1_O + REG_IDX_W;
   localparam int RD_O  = RS2_O + REG_IDX_W;
   localparam int RW_O  = RD_O + REG_IDX_W;
   localparam int MR_O  = RW_O + 1;
   localparam int HDR_W = MR_O + 1;
   localparam logic [HDR_W-1:0] BUBBLE = '0;
endpackage

// File: rtl/id_ex_lane_reg.sv
// id_ex_lane_reg: one lane's ID->EX register word with async reset and bubble insert
module id_ex_lane_reg
   import pipe_pkg::*;
#(
   parameter int W = HDR_W + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bubble_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] lane_q;
   // Latch the decode word, or a fully zeroed bubble
   always_ff @(posedge clk or posedge rst)
      if (rst) lane_q <= '0;
      else     lane_q <= bubble_i ? {{(W-HDR_W){1'b0}}, BUBBLE} : d_i;
   assign q_o = lane_q;
endmodule

// File: rtl/id_ex_dual_stage.sv
// id_ex_dual_stage: dual-lane ID->EX register with load-use interlock and pair split (ID_EX_STALL_CNT_EN adds stall counter)
module id_ex_dual_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            FlushE,
   input  logic [NUM_LANES-1:0]            ValidD,
   input  logic [NUM_LANES*REG_IDX_W-1:0]  Rs1_D,
   input  logic [NUM_LANES*REG_IDX_W-1:0]  Rs2_D,
   input  logic [NUM_LANES*REG_IDX_W-1:0]  RD_D,
   input  logic [NUM_LANES-1:0]            RegWriteD,
   input  logic [NUM_LANES-1:0]            MemReadD,
   input  logic [NUM_LANES*DATA_W-1:0]     RD1_D,
   input  logic [NUM_LANES*DATA_W-1:0]     RD2_D,
   input  logic [NUM_LANES*DATA_W-1:0]     ImmD,
   input  logic [NUM_LANES*DATA_W-1:0]     PCD,
   input  logic [NUM_LANES*CTRL_W-1:0]     CtrlD,
   output logic [NUM_LANES-1:0]            ValidE,
   output logic [NUM_LANES*REG_IDX_W-1:0]  Rs1_E,
   output logic [NUM_LANES*REG_IDX_W-1:0]  Rs2_E,
   output logic [NUM_LANES*REG_IDX_W-1:0]  RD_E,
   output logic [NUM_LANES-1:0]            RegWriteE,
   output logic [NUM_LANES-1:0]            MemReadE,
   output logic [NUM_LANES*DATA_W-1:0]     RD1_E,
   output logic [NUM_LANES*DATA_W-1:0]     RD2_E,
   output logic [NUM_LANES*DATA_W-1:0]     ImmE,
   output logic [NUM_LANES*DATA_W-1:0]     PCE,
   output logic [NUM_LANES*CTRL_W-1:0]     CtrlE,
   output logic                            StallD,
   output logic [31:0]                     StallCount
);
   localparam int LW = HDR_W + 4*DATA_W + CTRL_W;
   state_t state_q, state_d;
   logic load_use, pair_dep;
   logic [NUM_LANES-1:0] bubble;
   logic [LW-1:0] lane_d [NUM_LANES];
   logic [LW-1:0] lane_q [NUM_LANES];
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_d[g] = {CtrlD[g*CTRL_W +: CTRL_W], PCD[g*DATA_W +: DATA_W], ImmD[g*DATA_W +: DATA_W],
                          RD2_D[g*DATA_W +: DATA_W], RD1_D[g*DATA_W +: DATA_W], MemReadD[g], RegWriteD[g],
                          RD_D[g*REG_IDX_W +: REG_IDX_W], Rs2_D[g*REG_IDX_W +: REG_IDX_W],
                          Rs1_D[g*REG_IDX_W +: REG_IDX_W], ValidD[g]};
      id_ex_lane_reg #(.W(LW)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .bubble_i (bubble[g]),
         .d_i      (lane_d[g]),
         .q_o      (lane_q[g])
      );
      assign ValidE[g]                       = lane_q[g][V_O];
      assign Rs1_E[g*REG_IDX_W +: REG_IDX_W] = lane_q[g][RS1_O +: REG_IDX_W];
      assign Rs2_E[g*REG_IDX_W +: REG_IDX_W] = lane_q[g][RS2_O +: REG_IDX_W];
      assign RD_E[g*REG_IDX_W +: REG_IDX_W]  = lane_q[g][RD_O +: REG_IDX_W];
      assign RegWriteE[g]                    = lane_q[g][RW_O];
      assign MemReadE[g]                     = lane_q[g][MR_O];
      assign RD1_E[g*DATA_W +: DATA_W]       = lane_q[g][HDR_W +: DATA_W];
      assign RD2_E[g*DATA_W +: DATA_W]       = lane_q[g][HDR_W+DATA_W +: DATA_W];
      assign ImmE[g*DATA_W +: DATA_W]        = lane_q[g][HDR_W+2*DATA_W +: DATA_W];
      assign PCE[g*DATA_W +: DATA_W]         = lane_q[g][HDR_W+3*DATA_W +: DATA_W];
      assign CtrlE[g*CTRL_W +: CTRL_W]       = lane_q[g][HDR_W+4*DATA_W +: CTRL_W];
   end
   // Load in EX feeding a valid decode source; in SPLIT lane1 already issued so only lane2 matters
   always_comb begin
      load_use = 1'b0;
      for (int k = 0; k < NUM_LANES; k++)
         for (int j = 0; j < NUM_LANES; j++)
            if (ValidE[k] && MemReadE[k] && RD_E[k*REG_IDX_W +: REG_IDX_W] != '0 && ValidD[j] &&
                (state_q == ISSUE || j == 1) &&
                (RD_E[k*REG_IDX_W +: REG_IDX_W] == Rs1_D[j*REG_IDX_W +: REG_IDX_W] ||
                 RD_E[k*REG_IDX_W +: REG_IDX_W] == Rs2_D[j*REG_IDX_W +: REG_IDX_W]))
               load_use = 1'b1;
   end
   assign pair_dep = state_q == ISSUE && ValidD == 2'b11 && RegWriteD[0] && RD_D[4:0] != '0 &&
                     (RD_D[4:0] == Rs1_D[9:5] || RD_D[4:0] == Rs2_D[9:5]);
   // Bubble selects, decode stall and next state with priority FlushE > LoadUse > PairDep
   always_comb begin
      bubble[0] = FlushE | load_use | (state_q == SPLIT) | ~ValidD[0];
      bubble[1] = FlushE | load_use | pair_dep | ~ValidD[1];
      StallD    = ~FlushE & (load_use | pair_dep);
      state_d   = FlushE ? ISSUE : load_use ? state_q : pair_dep ? SPLIT : ISSUE;
   end
   // Split-state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= ISSUE;
      else     state_q <= state_d;
`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   // Saturating count of stalled decode cycles
   always_comb stall_cnt_d = (StallD && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   // Stall counter register
   always_ff @(posedge clk or posedge rst)
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   assign StallCount = stall_cnt_q;
`else
   assign StallCount = '0;
`endif
endmodule

// File: tb/tb_id_ex_dual_stage.sv
// tb_id_ex_dual_stage: directed self-checking bench for id_ex_dual_stage
module tb_id_ex_dual_stage;
   typedef logic [153:0] lane_t;
`ifdef ID_EX_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   logic clk, rst, FlushE;
   logic [1:0] ValidD, RegWriteD, MemReadD, ValidE, RegWriteE, MemReadE;
   logic [9:0] Rs1_D, Rs2_D, RD_D, Rs1_E, Rs2_E, RD_E;
   logic [63:0] RD1_D, RD2_D, ImmD, PCD, RD1_E, RD2_E, ImmE, PCE;
   logic [15:0] CtrlD, CtrlE;
   logic StallD;
   logic [31:0] StallCount;
   int checks = 0, errors = 0;
   lane_t a, b, ld, add, p1, p2;

   id_ex_dual_stage dut (
      .clk(clk), .rst(rst), .FlushE(FlushE), .ValidD(ValidD), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
      .RD_D(RD_D), .RegWriteD(RegWriteD), .MemReadD(MemReadD), .RD1_D(RD1_D), .RD2_D(RD2_D),
      .ImmD(ImmD), .PCD(PCD), .CtrlD(CtrlD), .ValidE(ValidE), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .RD_E(RD_E), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .RD1_E(RD1_E), .RD2_E(RD2_E),
      .ImmE(ImmE), .PCE(PCE), .CtrlE(CtrlE), .StallD(StallD), .StallCount(StallCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic lane_t lv(input logic v, input logic [4:0] rs1, rs2, rd, input logic rw, mr,
                                input logic [31:0] base);
      return {v, rs1, rs2, rd, rw, mr, base, ~base, base << 4, base + 32'h1000, base[7:0]};
   endfunction

   function automatic lane_t e_lane(input int k);
      return {ValidE[k], Rs1_E[k*5 +: 5], Rs2_E[k*5 +: 5], RD_E[k*5 +: 5], RegWriteE[k], MemReadE[k],
              RD1_E[k*32 +: 32], RD2_E[k*32 +: 32], ImmE[k*32 +: 32], PCE[k*32 +: 32], CtrlE[k*8 +: 8]};
   endfunction

   task automatic set_d(input int j, input lane_t x);
      {ValidD[j], Rs1_D[j*5 +: 5], Rs2_D[j*5 +: 5], RD_D[j*5 +: 5], RegWriteD[j], MemReadD[j],
       RD1_D[j*32 +: 32], RD2_D[j*32 +: 32], ImmD[j*32 +: 32], PCD[j*32 +: 32], CtrlD[j*8 +: 8]} = x;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      FlushE = 1'b0;
      set_d(0, '0);
      set_d(1, '0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (e_lane(0) !== '0 || e_lane(1) !== '0) begin
         errors++;
         $display("FAIL reset_ex got %h/%h exp 0", e_lane(1), e_lane(0));
      end
      checks++;
      if (StallD !== 1'b0 || StallCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_stall got %b/%h exp 0/0", StallD, StallCount);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) begin
         a = lv(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h100 + i);
         b = lv(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 32'h200 + i);
         set_d(0, a);
         set_d(1, b);
         #1;
         checks++;
         if (StallD !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall got %b exp 0", StallD);
         end
         tick;
         checks++;
         if (e_lane(0) !== a || e_lane(1) !== b) begin
            errors++;
            $display("FAIL b2b_ex got %h/%h exp %h/%h", e_lane(1), e_lane(0), b, a);
         end
      end
   endtask

   task automatic test_load_use;
      ld = lv(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 32'h300);
      set_d(0, ld);
      set_d(1, '0);
      tick;
      checks++;
      if (e_lane(0) !== ld) begin
         errors++;
         $display("FAIL lu_load got %h exp %h", e_lane(0), ld);
      end
      add = lv(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 32'h310);
      set_d(0, add);
      #1;
      checks++;
      if (StallD !== 1'b1) begin
         errors++;
         $display("FAIL lu_stall got %b exp 1", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== '0 || e_lane(1) !== '0 || StallD !== 1'b0) begin
         errors++;
         $display("FAIL lu_bubble got %h/%h stall %b exp 0/0 stall 0", e_lane(1), e_lane(0), StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== add || e_lane(1) !== '0) begin
         errors++;
         $display("FAIL lu_issue got %h/%h exp 0/%h", e_lane(1), e_lane(0), add);
      end
      checks++;
      if (StallCount !== (CNT_EN ? 32'd1 : 32'd0)) begin
         errors++;
         $display("FAIL lu_count got %0d exp %0d", StallCount, CNT_EN ? 1 : 0);
      end
   endtask

   task automatic test_pair_dep;
      p1 = lv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h400);
      p2 = lv(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 32'h410);
      set_d(0, p1);
      set_d(1, p2);
      #1;
      checks++;
      if (StallD !== 1'b1) begin
         errors++;
         $display("FAIL pd_stall got %b exp 1", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== p1 || e_lane(1) !== '0 || StallD !== 1'b0) begin
         errors++;
         $display("FAIL pd_first got %h/%h stall %b exp 0/%h stall 0", e_lane(1), e_lane(0), StallD, p1);
      end
      tick;
      checks++;
      if (e_lane(0) !== '0 || e_lane(1) !== p2) begin
         errors++;
         $display("FAIL pd_second got %h/%h exp %h/0", e_lane(1), e_lane(0), p2);
      end
      a = lv(1'b1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b0, 32'h420);
      b = lv(1'b1, 5'd13, 5'd14, 5'd15, 1'b1, 1'b0, 32'h430);
      set_d(0, a);
      set_d(1, b);
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++;
         $display("FAIL pd_resume_stall got %b exp 0", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== a || e_lane(1) !== b) begin
         errors++;
         $display("FAIL pd_resume got %h/%h exp %h/%h", e_lane(1), e_lane(0), b, a);
      end
      checks++;
      if (StallCount !== (CNT_EN ? 32'd2 : 32'd0)) begin
         errors++;
         $display("FAIL pd_count got %0d exp %0d", StallCount, CNT_EN ? 2 : 0);
      end
   endtask

   task automatic test_flush;
      set_d(0, p1);
      set_d(1, p2);
      tick;
      FlushE = 1'b1;
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++;
         $display("FAIL fl_split_stall got %b exp 0", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== '0 || e_lane(1) !== '0) begin
         errors++;
         $display("FAIL fl_split_ex got %h/%h exp 0/0", e_lane(1), e_lane(0));
      end
      FlushE = 1'b0;
      a = lv(1'b1, 5'd16, 5'd17, 5'd18, 1'b1, 1'b0, 32'h440);
      b = lv(1'b1, 5'd19, 5'd20, 5'd21, 1'b0, 1'b0, 32'h450);
      set_d(0, a);
      set_d(1, b);
      tick;
      checks++;
      if (e_lane(0) !== a || e_lane(1) !== b) begin
         errors++;
         $display("FAIL fl_after got %h/%h exp %h/%h", e_lane(1), e_lane(0), b, a);
      end
      ld = lv(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 32'h460);
      set_d(0, ld);
      set_d(1, '0);
      tick;
      add = lv(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 32'h470);
      set_d(0, add);
      FlushE = 1'b1;
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++;
         $display("FAIL fl_lu_stall got %b exp 0", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== '0 || e_lane(1) !== '0) begin
         errors++;
         $display("FAIL fl_lu_ex got %h/%h exp 0/0", e_lane(1), e_lane(0));
      end
      FlushE = 1'b0;
      tick;
      checks++;
      if (e_lane(0) !== add) begin
         errors++;
         $display("FAIL fl_lu_issue got %h exp %h", e_lane(0), add);
      end
   endtask

   task automatic test_x0_invalid;
      ld = lv(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h500);
      set_d(0, ld);
      set_d(1, '0);
      tick;
      a = lv(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h510);
      b = lv(1'b1, 5'd0, 5'd2, 5'd11, 1'b1, 1'b0, 32'h520);
      set_d(0, a);
      set_d(1, b);
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++;
         $display("FAIL x0_stall got %b exp 0", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== a || e_lane(1) !== b) begin
         errors++;
         $display("FAIL x0_ex got %h/%h exp %h/%h", e_lane(1), e_lane(0), b, a);
      end
      ld = lv(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 32'h530);
      set_d(0, ld);
      set_d(1, '0);
      tick;
      a = lv(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 32'h540);
      b = lv(1'b0, 5'd7, 5'd12, 5'd13, 1'b1, 1'b1, 32'h550);
      set_d(0, a);
      set_d(1, b);
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++;
         $display("FAIL inv_stall got %b exp 0", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== a || e_lane(1) !== '0) begin
         errors++;
         $display("FAIL inv_ex got %h/%h exp 0/%h", e_lane(1), e_lane(0), a);
      end
      checks++;
      if (StallCount !== (CNT_EN ? 32'd3 : 32'd0)) begin
         errors++;
         $display("FAIL inv_count got %0d exp %0d", StallCount, CNT_EN ? 3 : 0);
      end
   endtask

   task automatic test_reset_split;
      p1 = lv(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h600);
      p2 = lv(1'b1, 5'd4, 5'd3, 5'd9, 1'b1, 1'b0, 32'h610);
      set_d(0, p1);
      set_d(1, p2);
      tick;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (e_lane(0) !== '0 || e_lane(1) !== '0 || StallCount !== 32'd0) begin
         errors++;
         $display("FAIL rst_split got %h/%h cnt %0d exp 0/0 cnt 0", e_lane(1), e_lane(0), StallCount);
      end
      #1 rst = 1'b0;
      a = lv(1'b1, 5'd22, 5'd23, 5'd24, 1'b1, 1'b0, 32'h620);
      b = lv(1'b1, 5'd25, 5'd26, 5'd27, 1'b1, 1'b0, 32'h630);
      set_d(0, a);
      set_d(1, b);
      #1;
      checks++;
      if (StallD !== 1'b0) begin
         errors++;
         $display("FAIL rst_resume_stall got %b exp 0", StallD);
      end
      tick;
      checks++;
      if (e_lane(0) !== a || e_lane(1) !== b) begin
         errors++;
         $display("FAIL rst_resume got %h/%h exp %h/%h", e_lane(1), e_lane(0), b, a);
      end
   endtask

`ifdef ID_EX_STALL_CNT_EN
   task automatic test_saturate;
      set_d(0, p1);
      set_d(1, p2);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      tick;
      release dut.stall_cnt_q;
      set_d(0, '0);
      set_d(1, '0);
      tick;
      set_d(0, p1);
      set_d(1, p2);
      #1;
      checks++;
      if (StallD !== 1'b1) begin
         errors++;
         $display("FAIL sat_stall got %b exp 1", StallD);
      end
      tick;
      checks++;
      if (StallCount !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL sat_count got %h exp ffffffff", StallCount);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_back_to_back;
      test_load_use;
      test_pair_dep;
      test_flush;
      test_x0_invalid;
      test_reset_split;
`ifdef ID_EX_STALL_CNT_EN
      test_saturate;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
